// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the future receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Line bits per frame: start + 8 data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + 8 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud clock-enable: one-cycle tick every PRESCALER cycles while running.
module baud_tick_gen #(
  parameter int unsigned PRESCALER = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(PRESCALER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALER - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign o_tick = i_run && (r_cnt == CNT_LAST);

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear) begin
      w_cnt_next = '0;
    end else if (i_run) begin
      w_cnt_next = o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: sends the captured word MSB byte first, one
// 8-bit frame per byte, back to back, with optional parity and 1-2 stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned BAUD_PRESCALER = 200,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [8*WORD_BYTES-1:0]            i_data,
  input  logic [$clog2(WORD_BYTES+1)-1:0]    i_len,
  input  logic                               i_start,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_tx_pin
);

  localparam int unsigned LEN_W  = $clog2(WORD_BYTES + 1);
  localparam int unsigned WORD_W = 8 * WORD_BYTES;

  if (WORD_BYTES < 1 || WORD_BYTES > 16) begin : g_bad_word_bytes
    $error("uart_tx_frame: WORD_BYTES must be 1..16");
  end
  if (BAUD_PRESCALER < 2) begin : g_bad_prescaler
    $error("uart_tx_frame: BAUD_PRESCALER must be >= 2");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_state_e        r_state, w_state_next;
  logic [WORD_W-1:0]  r_word, w_word_next;
  logic [LEN_W-1:0]   r_len, w_len_next;
  logic [LEN_W-1:0]   r_byte_cnt, w_byte_cnt_next;
  logic [2:0]         r_bit_idx, w_bit_idx_next;
  logic               r_stop_cnt, w_stop_cnt_next;
  logic               r_tx, w_tx_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;

  logic               w_accept;
  logic               w_tick;
  logic [LEN_W-1:0]   w_len_eff;
  logic [7:0]         w_cur_byte;
  logic [2:0]         w_bit_inc;
  logic               w_parity_bit;
  logic               w_last_byte;
  logic               w_last_stop;

  assign w_accept    = i_start && !r_busy;
  // Current byte always sits at the top of the word; it is shifted up per byte.
  assign w_cur_byte  = r_word[WORD_W-1 -: 8];
  assign w_bit_inc   = r_bit_idx + 3'd1;
  assign w_parity_bit = (PARITY == PARITY_ODD) ? ~(^w_cur_byte) : ^w_cur_byte;
  assign w_last_byte = (r_byte_cnt == r_len - LEN_W'(1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

  always_comb begin
    w_len_eff = i_len;
    if (i_len == '0 || i_len > LEN_W'(WORD_BYTES)) begin
      w_len_eff = LEN_W'(WORD_BYTES);
    end
  end

  baud_tick_gen #(
    .PRESCALER(BAUD_PRESCALER)
  ) u_baud_tick_gen (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_run  (r_busy),
    .i_clear(w_accept),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_word_next     = r_word;
    w_len_next      = r_len;
    w_byte_cnt_next = r_byte_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_stop_cnt_next = r_stop_cnt;
    w_tx_next       = r_tx;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_state_next    = StStart;
          w_word_next     = i_data;
          w_len_next      = w_len_eff;
          w_byte_cnt_next = '0;
          w_bit_idx_next  = '0;
          w_stop_cnt_next = 1'b0;
          w_tx_next       = 1'b0;
          w_busy_next     = 1'b1;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_next   = StData;
          w_bit_idx_next = '0;
          w_tx_next      = w_cur_byte[0];
        end
      end
      StData: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              w_state_next = StParity;
              w_tx_next    = w_parity_bit;
            end else begin
              w_state_next    = StStop;
              w_stop_cnt_next = 1'b0;
              w_tx_next       = 1'b1;
            end
          end else begin
            w_bit_idx_next = w_bit_inc;
            w_tx_next      = w_cur_byte[w_bit_inc];
          end
        end
      end
      StParity: begin
        if (w_tick) begin
          w_state_next    = StStop;
          w_stop_cnt_next = 1'b0;
          w_tx_next       = 1'b1;
        end
      end
      StStop: begin
        if (w_tick) begin
          if (!w_last_stop) begin
            w_stop_cnt_next = 1'b1;
          end else if (w_last_byte) begin
            w_state_next = StIdle;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_tx_next    = 1'b1;
          end else begin
            // Next frame starts immediately: no idle gap between bytes.
            w_state_next    = StStart;
            w_word_next     = r_word << 8;
            w_byte_cnt_next = r_byte_cnt + LEN_W'(1);
            w_stop_cnt_next = 1'b0;
            w_tx_next       = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_word     <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_word     <= w_word_next;
      r_len      <= w_len_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_tx_pin = r_tx;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises a multi-byte word into consecutive 8-bit UART frames, with configurable word width, baud divisor, parity and stop-bit count. A per-request byte count allows partial words. All logic runs on a single system clock; the baud rate comes from a clock-enable tick, not a derived clock. It sits between the capture/readout logic and the host serial pin, and replaces the fixed 32-bit, 1-stop, no-parity transmitter.

Parameters:
WORD_BYTES, 4, number of bytes in the data word (1..16).
BAUD_PRESCALER, 200, i_clk cycles per UART bit (>=2); 200 gives 250000 baud at 50 MHz.
PARITY, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal (elaboration error).
STOP_BITS, 1, stop-bit count per frame (1 or 2).

Ports:
i_clk  in  1  system clock, rising edge.
_rst  in  1  reset; asynchronous, active-low.
data  in  8*WORD_BYTES  word to send; byte WORD_BYTES-1 (MSB) is sent first.
len  in  $clog2(WORD_BYTES+1)  number of bytes to send, starting from the MSB byte; 0 or >WORD_BYTES means WORD_BYTES.
start  in  1  request; sampled only while busy=0.
busy  out  1  high from the cycle after acceptance until the last stop bit completes.
done  out  1  one-cycle pulse at the end of the last stop bit.
tx_pin  out  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release): tx_pin=1, busy=0, done=0, FSM=IDLE, counters=0. Reset mid-frame aborts immediately: no done pulse, and the line returns high.
- Acceptance: at an edge where start=1 and busy=0, the block captures data and the clamped len into internal registers. busy=1 from the next cycle. start while busy=1 is ignored, with no queuing.
- Baud tick: a counter runs 0..BAUD_PRESCALER-1 only while busy, cleared on acceptance. tick=1 when count==BAUD_PRESCALER-1. Every bit is held exactly BAUD_PRESCALER cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. tx_pin=0 from the cycle after acceptance.
  - START -> DATA on tick.
  - DATA sends 8 bits LSB-first, using a 3-bit bit index. On tick with index 7: go to PARITY if PARITY!=0, else STOP.
  - PARITY sends XOR of the byte (even) or its inverse (odd). -> STOP on tick.
  - STOP holds tx_pin=1 for STOP_BITS ticks. Then:
    - bytes remaining: -> START for the next byte. No idle gap between frames.
    - last byte: -> IDLE, with busy=0 and done=1 in the same cycle.
- Byte selection: a byte counter counts 0..len-1 and selects data byte WORD_BYTES-1-counter. Use a shift of the captured word by 8, not a wide mux, where it is cheaper.
- Frame length: 1+8+(PARITY?1:0)+STOP_BITS bits. busy is high for exactly len*frame_bits*BAUD_PRESCALER cycles.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted. The next start bit begins the following cycle.
- Captured data is immune to changes on data/len after acceptance.
- tx_pin is registered (glitch-free). done and busy are registered.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - PARITY_NONE/EVEN/ODD constants.
  - function frame_bits(parity, stop_bits).
- One sub-module, baud_tick_gen: parameter PRESCALER; ports i_clk, _rst, run, clear, tick. It is reusable by the future receiver.

Test Plan:
- WORD_BYTES=4, BAUD_PRESCALER=4, no parity, 1 stop; data=0xA1B2C3D4, len=4 -> frames A1, B2, C3, D4 in that order, LSB-first; busy high exactly 160 cycles; single done pulse; tx_pin=1 afterwards.
- PARITY=1 (even), len=1, data MSB byte 0xA1 (three ones) -> parity bit 1. PARITY=2 with the same byte -> parity bit 0. busy lasts 11*4=44 cycles.
- STOP_BITS=2, len=2, data=0x55AA.... -> each stop period lasts 8 cycles of high. The second start bit falls exactly 11*4 cycles after the first. Total busy 88 cycles.
- len=0 and len=7 with WORD_BYTES=4 -> both send 4 bytes. start pulsed mid-transfer with new data -> ignored, and the original bytes complete.
- start held high continuously, len=1, data=0x00 -> consecutive frames with no idle cycle. done pulses every 40 cycles. Each acceptance occurs in the done cycle.
- _rst asserted 17 cycles into byte 2 -> tx_pin=1 and busy=0 asynchronously, with no done pulse. After release, a start with 0x0F sends a clean single frame.
